tdm_demux_1x8: RTL



---
 rtl/tdm_pkg.sv | 22 ++
 rtl/tdm_slot_counter.sv | 27 ++
 rtl/tdm_demux_1x8.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared types and sizing for the TDM demultiplexer.
// Build option: TDM_PARITY_EN adds a ninth parity slot to each frame.
package tdm_pkg;

  // Framing FSM state encoding.
  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int NUM_CH = 8;
  localparam int CH_W   = $clog2(NUM_CH);

`ifdef TDM_PARITY_EN
  localparam int LAST_SLOT = 8;
`else
  localparam int LAST_SLOT = 7;
`endif

  localparam int SEL_W = $clog2(LAST_SLOT + 1);

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot counter for the TDM demux: counts valid slots, reloads on sync.
// Ports: clk, rst (async high), en (advance), load (force to slot 1), cnt, last.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  output logic [SEL_W-1:0] cnt,
  output logic             last
);

  assign last = (cnt == SEL_W'(LAST_SLOT));

  // A sync sample always lands in slot 0, so the slot after it is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= SEL_W'(1);
    end else if (en) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux_1x8.sv
// TDM 1x8 demux: steers serial samples into eight double-buffered channels.
// Ports: clk, rst, in, in_valid, frame_sync -> sel, y0..y7, frame_done,
// sync_err, locked (+ parity_err when TDM_PARITY_EN is defined).
module tdm_demux_1x8
  import tdm_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic              in_valid,
  input  logic              frame_sync,
  output logic [2:0]        sel,
  output logic [DATA_W-1:0] y0,
  output logic [DATA_W-1:0] y1,
  output logic [DATA_W-1:0] y2,
  output logic [DATA_W-1:0] y3,
  output logic [DATA_W-1:0] y4,
  output logic [DATA_W-1:0] y5,
  output logic [DATA_W-1:0] y6,
  output logic [DATA_W-1:0] y7,
  output logic              frame_done,
  output logic              sync_err,
  output logic              locked
`ifdef TDM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  state_t state;
  state_t state_nxt;

  logic [SEL_W-1:0] cnt;
  logic             last;
  logic             cnt_en;
  logic             cnt_load;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic             frame_end;
  logic             early;

  logic [DATA_W-1:0] shadow [NUM_CH];
  logic [DATA_W-1:0] ybank  [NUM_CH];

  tdm_slot_counter u_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .load (cnt_load),
    .cnt  (cnt),
    .last (last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: once locked, sync problems re-align in place.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_HUNT: begin
        if (in_valid && frame_sync) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_HUNT;
      end
    endcase
  end

  // Control decode.
  always_comb begin
    cnt_en    = 1'b0;
    cnt_load  = 1'b0;
    wr_en     = 1'b0;
    wr_ch     = cnt[CH_W-1:0];
    frame_end = 1'b0;
    early     = 1'b0;
    unique case (state)
      ST_HUNT: begin
        if (in_valid && frame_sync) begin
          cnt_load = 1'b1;
          wr_en    = 1'b1;
          wr_ch    = '0;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          if (frame_sync && cnt != '0) begin
            // Early sync: drop the partial frame, restart at ch0.
            early    = 1'b1;
            cnt_load = 1'b1;
            wr_en    = 1'b1;
            wr_ch    = '0;
          end else begin
            // Missing sync at slot 0 is accepted (flywheel).
            cnt_en    = 1'b1;
            frame_end = last;
`ifdef TDM_PARITY_EN
            wr_en     = !last;
`else
            wr_en     = 1'b1;
`endif
          end
        end
      end
      default: begin
        cnt_en = 1'b0;
      end
    endcase
  end

  assign locked = (state == ST_RUN);

`ifdef TDM_PARITY_EN
  logic par_calc;

  // Even parity across every bit of the eight shadowed channels.
  always_comb begin
    par_calc = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      par_calc = par_calc ^ (^shadow[i]);
    end
  end

  // The parity slot is not a channel; present it as 0.
  assign sel = last ? 3'd0 : cnt[2:0];
`else
  assign sel = cnt[2:0];
`endif

  // Shadow bank, output bank and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
        ybank[i]  <= '0;
      end
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
`ifdef TDM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_done <= frame_end;
      sync_err   <= early;
      if (wr_en) begin
        shadow[wr_ch] <= in;
      end
`ifdef TDM_PARITY_EN
      parity_err <= frame_end & (par_calc ^ in[0]);
      if (frame_end) begin
        for (int i = 0; i < NUM_CH; i++) begin
          ybank[i] <= shadow[i];
        end
      end
`else
      // ch7 bypasses the shadow so y is valid one clock after it.
      if (frame_end) begin
        for (int i = 0; i < NUM_CH - 1; i++) begin
          ybank[i] <= shadow[i];
        end
        ybank[NUM_CH-1] <= in;
      end
`endif
    end
  end

  assign y0 = ybank[0];
  assign y1 = ybank[1];
  assign y2 = ybank[2];
  assign y3 = ybank[3];
  assign y4 = ybank[4];
  assign y5 = ybank[5];
  assign y6 = ybank[6];
  assign y7 = ybank[7];

endmodule
